// File: rtl/button_dir_ctrl_if.sv
// rtl/button_dir_ctrl_if.sv - Push-button inputs and LED chaser control outputs of button_dir_ctrl
interface button_dir_ctrl_if;
    logic Key0;
    logic Key1;
    logic Right;
    logic Step;
    logic Running;

    modport master (output Key0, output Key1, input Right, input Step, input Running);
    modport slave  (input Key0, input Key1, output Right, output Step, output Running);
endinterface

// File: rtl/button_dir_ctrl.sv
// rtl/button_dir_ctrl.sv - Debounced direction/pause buttons and step tick generator for an LED chaser
// Optional feature: define DIR_CTRL_PAUSE_EN to enable the Key1 pause/run button.
module button_dir_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    typedef enum logic [1:0] {UP, WAIT_DOWN, DOWN, WAIT_UP} state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_press;
    logic          w_stable;

    // The cycle that left UP/DOWN already saw the new level, so the wait
    // states need DEBOUNCE_CYCLES-1 further stable cycles.
    assign w_stable = (int'(r_cnt) + 2 >= DEBOUNCE_CYCLES);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= UP;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            r_cnt   <= '0;
            case (r_state)
                UP: begin
                    if (!r_sync2) r_state <= WAIT_DOWN;
                end
                WAIT_DOWN: begin
                    if (r_sync2) begin
                        r_state <= UP;
                    end else if (w_stable) begin
                        r_state <= DOWN;
                        r_press <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DOWN: begin
                    if (r_sync2) r_state <= WAIT_UP;
                end
                WAIT_UP: begin
                    if (!r_sync2) begin
                        r_state <= DOWN;
                    end else if (w_stable) begin
                        r_state <= UP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= UP;
            endcase
        end
    end

    assign o_press = r_press;
endmodule

module button_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TICK_DIV        = 25000000
) (
    input logic               CLOCK_50,
    input logic               Reset,
    button_dir_ctrl_if.slave  bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic          w_press0;
    logic          w_running;
    logic          r_right;
    logic          r_step;
    logic [TW-1:0] r_tick;

    button_dir_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .i_clk   (CLOCK_50),
        .i_rst   (Reset),
        .i_key   (bus.Key0),
        .o_press (w_press0)
    );

`ifdef DIR_CTRL_PAUSE_EN
    logic w_press1;
    logic r_running;

    button_dir_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .i_clk   (CLOCK_50),
        .i_rst   (Reset),
        .i_key   (bus.Key1),
        .o_press (w_press1)
    );

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_running <= 1'b1;
        end else if (w_press1) begin
            r_running <= ~r_running;
        end
    end

    assign w_running = r_running;
`else
    logic w_unused_key1;
    assign w_unused_key1 = bus.Key1;
    assign w_running     = 1'b1;
`endif

    // Step uses the Running value of the terminal-count cycle, so a pause
    // landing on that cycle still lets the pending Step out.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            r_right <= 1'b1;
            r_step  <= 1'b0;
            r_tick  <= '0;
        end else begin
            if (w_press0) r_right <= ~r_right;
            r_step <= w_running && (r_tick == TICK_LAST);
            if (w_running) begin
                r_tick <= (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
            end
        end
    end

    assign bus.Right   = r_right;
    assign bus.Step    = r_step;
    assign bus.Running = w_running;
endmodule

// File: tb/tb_button_dir_ctrl.sv
// tb/tb_button_dir_ctrl.sv - Self-checking bench for button_dir_ctrl with a cycle-level behavioural model
module tb_button_dir_ctrl;
    localparam int DEB = 4;
    localparam int DIV = 5;
`ifdef DIR_CTRL_PAUSE_EN
    localparam bit PAUSE = 1'b1;
`else
    localparam bit PAUSE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    button_dir_ctrl_if bus ();

    button_dir_ctrl #(.DEBOUNCE_CYCLES(DEB), .TICK_DIV(DIV)) dut (
        .CLOCK_50 (clk),
        .Reset    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: sync pipeline, accepted key level, length of the current run of
    // disagreeing synced samples, pending press pulse, and running-cycle count.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_acc [2];
    bit m_pend [2];
    int m_run [2];
    bit m_right;
    bit m_step;
    bit m_running;
    int m_n;

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %b required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit key [2];
        @(posedge clk);
        #1;
        key[0] = bus.Key0;
        key[1] = bus.Key1;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_s1[k] = 1'b1; m_s2[k] = 1'b1; m_acc[k] = 1'b1;
                m_pend[k] = 1'b0; m_run[k] = 0;
            end
            m_right = 1'b1; m_step = 1'b0; m_running = 1'b1; m_n = 0;
        end else begin
            m_step = m_running && ((m_n + 1) % DIV == 0);
            if (m_running) m_n++;
            if (m_pend[0]) m_right = !m_right;
            if (PAUSE && m_pend[1]) m_running = !m_running;
            for (int k = 0; k < 2; k++) begin
                m_pend[k] = 1'b0;
                if (m_s2[k] != m_acc[k]) begin
                    m_run[k]++;
                    if (m_run[k] == DEB) begin
                        m_pend[k] = m_acc[k];
                        m_acc[k]  = !m_acc[k];
                        m_run[k]  = 0;
                    end
                end else begin
                    m_run[k] = 0;
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = key[k];
            end
        end
        chk_bit("model_right", bus.Right, m_right);
        chk_bit("model_step", bus.Step, m_step);
        chk_bit("model_running", bus.Running, m_running);
    endtask

    function automatic logic out_sig(input int sel);
        case (sel)
            0:       return bus.Right;
            1:       return bus.Step;
            default: return bus.Running;
        endcase
    endfunction

    task automatic wait_out(input string name, input int sel, input logic val, input int exp);
        int c = 0;
        do begin
            cycle();
            c++;
        end while (out_sig(sel) !== val && c < 40);
        chk_int(name, (out_sig(sel) === val) ? c : -1, exp);
    endtask

    task automatic count_steps(input int len, output int n);
        n = 0;
        for (int i = 0; i < len; i++) begin
            cycle();
            if (bus.Step === 1'b1) n++;
        end
    endtask

    initial begin
        int n;
        int hold [2];
        bus.Key0 = 1'b1;
        bus.Key1 = 1'b1;
        rst = 1'b1;
        repeat (3) cycle();
        chk_bit("reset_right", bus.Right, 1'b1);
        chk_bit("reset_step", bus.Step, 1'b0);
        chk_bit("reset_running", bus.Running, 1'b1);

        // Idle: Step every DIV cycles
        rst = 1'b0;
        wait_out("s1_first_step", 1, 1'b1, 5);
        wait_out("s1_period_a", 1, 1'b1, 5);
        wait_out("s1_period_b", 1, 1'b1, 5);
        chk_bit("s1_right", bus.Right, 1'b1);
        chk_bit("s1_running", bus.Running, 1'b1);

        // Held Key0: one toggle, 2 sync + 4 debounce + 1 cycles
        bus.Key0 = 1'b0;
        wait_out("s2_right_latency", 0, 1'b0, 7);
        repeat (3) cycle();
        bus.Key0 = 1'b1;
        repeat (12) cycle();
        chk_bit("s2_single_toggle", bus.Right, 1'b0);

        // Bounce shorter than the debounce window
        bus.Key0 = 1'b0; repeat (2) cycle();
        bus.Key0 = 1'b1; cycle();
        bus.Key0 = 1'b0; repeat (2) cycle();
        bus.Key0 = 1'b1; repeat (10) cycle();
        chk_bit("s3_right_unchanged", bus.Right, 1'b0);

        // Reset during WAIT_DOWN with tick count 3
        rst = 1'b1; cycle();
        rst = 1'b0; bus.Key0 = 1'b0;
        repeat (3) cycle();
        rst = 1'b1; bus.Key0 = 1'b1; cycle();
        rst = 1'b0;
        wait_out("s4_first_step", 1, 1'b1, 5);
        repeat (8) cycle();
        chk_bit("s4_right_kept", bus.Right, 1'b1);

`ifdef DIR_CTRL_PAUSE_EN
        // Pause with the tick held at 2, resume three cycles before Step
        rst = 1'b1; cycle();
        rst = 1'b0; bus.Key1 = 1'b0;
        wait_out("s5_pause_latency", 2, 1'b0, 7);
        repeat (3) cycle();
        bus.Key1 = 1'b1;
        count_steps(12, n);
        chk_int("s5_no_step_paused", n, 0);
        bus.Key1 = 1'b0;
        wait_out("s5_resume_latency", 2, 1'b1, 7);
        wait_out("s5_step_after_resume", 1, 1'b1, 3);
        bus.Key1 = 1'b1;
        repeat (8) cycle();
`endif

        // Simultaneous presses
        bus.Key0 = 1'b0; bus.Key1 = 1'b0;
        wait_out("s6_right_latency", 0, 1'b0, 7);
`ifdef DIR_CTRL_PAUSE_EN
        chk_bit("s6_running_same_edge", bus.Running, 1'b0);
`endif
        repeat (3) cycle();
        bus.Key0 = 1'b1; bus.Key1 = 1'b1;
        repeat (10) cycle();

        // Random key activity with occasional resets
        hold[0] = 1; hold[1] = 1;
        for (int i = 0; i < 1500; i++) begin
            hold[0]--; hold[1]--;
            if (hold[0] == 0) begin
                bus.Key0 = ~bus.Key0;
                hold[0] = int'($urandom_range(1, 12));
            end
            if (hold[1] == 0) begin
                bus.Key1 = ~bus.Key1;
                hold[1] = int'($urandom_range(1, 12));
            end
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/button_dir_ctrl.md
BUTTON_DIR_CTRL -- requirements
Module: button_dir_ctrl

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 1000000, is the number of consecutive stable CLOCK_50 cycles needed to accept a key level change (20 ms at 50 MHz).
- REQ-002: Parameter TICK_DIV, default 25000000, is the number of CLOCK_50 cycles per Step pulse; legal range 2..2^26.
- REQ-003: CLOCK_50  input  1  system clock; every flop clocks on its rising edge.
- REQ-004: Reset  input  1  synchronous, active-high reset.
- REQ-005: Key0  input  1  asynchronous, active-low direction push button; each press toggles direction.
- REQ-006: Key1  input  1  asynchronous, active-low pause/run push button; used only when DIR_CTRL_PAUSE_EN is defined.
- REQ-007: Right  output  1  registered direction to the LED chaser; 1 = shift up, 0 = shift down.
- REQ-008: Step  output  1  registered single-cycle pulse that advances the LED chaser one position.
- REQ-009: Running  output  1  registered level; 1 = Step pulses enabled.

Function
- REQ-010: Each key SHALL pass through a 2-flop synchronizer before any other logic uses it.
- REQ-011: Each key SHALL have its own debounce FSM with states UP, WAIT_DOWN, DOWN and WAIT_UP.
- REQ-012: Debounce transitions (sync = synchronized key level, counter clears on every state entry):
  - UP -> WAIT_DOWN when sync = 0.
  - WAIT_DOWN -> UP when sync = 1.
  - WAIT_DOWN -> DOWN when the counter reaches DEBOUNCE_CYCLES-1 with sync still 0.
  - DOWN -> WAIT_UP when sync = 1.
  - WAIT_UP -> DOWN when sync = 0.
  - WAIT_UP -> UP when the counter reaches DEBOUNCE_CYCLES-1 with sync still 1.
- REQ-013: The WAIT_DOWN -> DOWN transition SHALL raise an internal press pulse for exactly one cycle; a release SHALL raise no pulse.
- REQ-014: A held key SHALL produce exactly one press pulse, with no auto-repeat.
- REQ-015: A Key0 press pulse SHALL invert Right on the following clock edge.
- REQ-016: The tick counter SHALL count 0..TICK_DIV-1 and wrap to 0.
- REQ-017: Step SHALL be 1 for exactly the one cycle after the tick counter holds TICK_DIV-1 while Running = 1.
- REQ-018: While Running = 0, the tick counter SHALL hold its value and Step SHALL stay 0; counting SHALL resume from the held value.
- REQ-019: A Step coincident with a Right change SHALL NOT be suppressed; the consumer samples Right in the same cycle that Step = 1.
- REQ-020: Counter widths SHALL be $clog2 of the parameter, with no overflow at the maximum value.
- REQ-021: Simultaneous Key0 and Key1 press pulses SHALL both take effect in the same cycle.

Reset
- REQ-022: While Reset = 1 at a clock edge, the following SHALL load on that edge:
  - Right = 1, Step = 0, Running = 1;
  - both debounce FSMs = UP;
  - all counters = 0;
  - synchronizer flops = 1.
- REQ-023: A Reset asserted mid-debounce or mid-count SHALL abandon that operation with no press pulse or Step generated.
- REQ-024: In the first cycle after Reset deasserts, the block SHALL resume counting from 0.

Configuration
- REQ-025: With DIR_CTRL_PAUSE_EN defined, a Key1 press pulse SHALL toggle Running on the following edge.
- REQ-026: Without DIR_CTRL_PAUSE_EN, the Key1 synchronizer and debounce logic SHALL be absent, Key1 SHALL be ignored, and Running SHALL be tied to 1.

Verification
- REQ-027: The bench SHALL use DEBOUNCE_CYCLES = 4 and TICK_DIV = 5 for all scenarios below.
- REQ-028: Scenario 1: release Reset and idle -> Step pulses every 5 cycles, Right = 1, Running = 1.
- REQ-029: Scenario 2: hold Key0 low for 10 cycles -> Right toggles exactly once; Right = 0 within 2+4+1 cycles of the key falling.
- REQ-030: Scenario 3: bounce Key0 low for 2 cycles, high for 1, low for 2, then high -> Right unchanged.
- REQ-031: Scenario 4: assert Reset during WAIT_DOWN and tick count 3 -> no Right change; first Step arrives 5 cycles after Reset deasserts.
- REQ-032: Scenario 5 (DIR_CTRL_PAUSE_EN): press Key1 at tick count 2 -> Step stops; press Key1 again -> next Step arrives 3 cycles later.
- REQ-033: Scenario 6: press Key0 and Key1 simultaneously -> Right and Running both toggle on the same edge.
